// File: rtl/bomb_blast.sv
// bomb_blast: turns a bomb's blast pulse into a cross-shaped flame on the
// 20x15 tile grid. It probes the tile map arm by arm, reports destroyed
// bricks, holds the flame for BURN_FRAMES frames and flags a player hit.
module bomb_blast #(
    parameter int RANGE       = 2,   // maximum arm length in tiles (1..7)
    parameter int BURN_FRAMES = 30   // frames the flame stays visible
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               blast,
    input  logic signed [10:0] bomb_topLeftX,
    input  logic signed [10:0] bomb_topLeftY,
    output logic               tile_req,
    output logic [4:0]         tile_col,
    output logic [3:0]         tile_row,
    input  logic [1:0]         tile_type,
    output logic               destroy_valid,
    output logic [4:0]         destroy_col,
    output logic [3:0]         destroy_row,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic [10:0]        player_topLeftX,
    input  logic [10:0]        player_topLeftY,
    output logic               flame_active,
    output logic               flameDR,
    output logic               player_hit,
    output logic               done
);

    localparam int FW = $clog2(BURN_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, LATCH, PROBE_REQ, PROBE_RSP, BURN, DONE} state_t;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_BRICK = 2'd2;

    state_t               state;
    logic signed [10:0]   pos_x, pos_y;
    logic [4:0]           cx;
    logic [3:0]           cy;
    logic [3:0][2:0]      arm;        // index = direction: 0 L, 1 R, 2 U, 3 D
    logic [1:0]           dir;
    logic [2:0]           step;
    logic [FW-1:0]        frame_cnt;
    logic                 hit_flag;

    // Centre tile from the latched bomb position, rounded to the nearest tile
    logic signed [11:0]   sum_x, sum_y, raw_cx, raw_cy;
    logic [4:0]           cx_clamp;
    logic [3:0]           cy_clamp;

    assign sum_x    = {pos_x[10], pos_x} + 12'sd16;
    assign sum_y    = {pos_y[10], pos_y} + 12'sd16;
    assign raw_cx   = sum_x >>> 5;
    assign raw_cy   = sum_y >>> 5;
    assign cx_clamp = (raw_cx < 12'sd0) ? 5'd0 : (raw_cx > 12'sd19) ? 5'd19 : raw_cx[4:0];
    assign cy_clamp = (raw_cy < 12'sd0) ? 4'd0 : (raw_cy > 12'sd14) ? 4'd14 : raw_cy[3:0];

    // Probe target: centre offset by step in the current direction
    logic signed [6:0]    tgt_col, tgt_row, step_s, base_col, base_row;
    logic                 off_grid;

    assign base_col = $signed({2'b00, cx});
    assign base_row = $signed({3'b000, cy});
    assign step_s   = $signed({4'b0000, step});

    // Select the target tile for direction dir
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        tgt_col = base_col;
        tgt_row = base_row;
        case (dir)
            2'd0:    tgt_col = base_col - step_s;
            2'd1:    tgt_col = base_col + step_s;
            2'd2:    tgt_row = base_row - step_s;
            default: tgt_row = base_row + step_s;
        endcase
    end

    assign off_grid = (tgt_col < 7'sd0) || (tgt_col > 7'sd19) ||
                      (tgt_row < 7'sd0) || (tgt_row > 7'sd14);

    // Tile-map port and brick report; the response is consumed in PROBE_RSP.
    // destroy_valid is masked by reset so an aborted probe never consumes a brick.
    assign tile_req      = (state == PROBE_REQ) && !off_grid;
    assign tile_col      = tile_req ? tgt_col[4:0] : 5'd0;
    assign tile_row      = tile_req ? tgt_row[3:0] : 4'd0;
    assign destroy_valid = !reset && (state == PROBE_RSP) && (tile_type == TILE_BRICK);
    assign destroy_col   = destroy_valid ? tgt_col[4:0] : 5'd0;
    assign destroy_row   = destroy_valid ? tgt_row[3:0] : 4'd0;

    // Decide whether the current direction finishes this cycle
    logic close_dir;
    always_comb begin
        close_dir = 1'b0;
        case (state)
            PROBE_REQ: close_dir = off_grid;
            PROBE_RSP: close_dir = (tile_type != TILE_EMPTY) || (step == 3'(RANGE));
            default:   close_dir = 1'b0;
        endcase
    end

    // Flame cross in tile units; bounds come straight from registers
    logic [6:0] cx7, cy7, col_lo, col_hi, row_lo, row_hi;
    logic [6:0] pix_col, pix_row, ply_col, ply_row;
    logic       pix_in, ply_in;

    assign cx7     = {2'b00, cx};
    assign cy7     = {3'b000, cy};
    assign col_lo  = cx7 - {4'b0000, arm[0]};
    assign col_hi  = cx7 + {4'b0000, arm[1]};
    assign row_lo  = cy7 - {4'b0000, arm[2]};
    assign row_hi  = cy7 + {4'b0000, arm[3]};
    assign pix_col = 7'(pixelX >> 5);
    assign pix_row = 7'(pixelY >> 5);
    assign ply_col = 7'((12'(player_topLeftX) + 12'd16) >> 5);
    assign ply_row = 7'((12'(player_topLeftY) + 12'd16) >> 5);

    assign pix_in = ((pix_row == cy7) && (pix_col >= col_lo) && (pix_col <= col_hi)) ||
                    ((pix_col == cx7) && (pix_row >= row_lo) && (pix_row <= row_hi));
    assign ply_in = ((ply_row == cy7) && (ply_col >= col_lo) && (ply_col <= col_hi)) ||
                    ((ply_col == cx7) && (ply_row >= row_lo) && (ply_row <= row_hi));

    assign flameDR = flame_active && pix_in;

    // Main FSM: latch, probe four arms, burn for BURN_FRAMES frames, finish
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pos_x        <= '0;
            pos_y        <= '0;
            cx           <= '0;
            cy           <= '0;
            arm          <= '0;
            dir          <= '0;
            step         <= '0;
            frame_cnt    <= '0;
            hit_flag     <= 1'b0;
            flame_active <= 1'b0;
            player_hit   <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; later ones in this block override earlier ones.
            done       <= 1'b0;
            player_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (blast) begin
                        pos_x <= bomb_topLeftX;
                        pos_y <= bomb_topLeftY;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    cx        <= cx_clamp;
                    cy        <= cy_clamp;
                    arm       <= '0;
                    dir       <= 2'd0;
                    step      <= 3'd1;
                    frame_cnt <= '0;
                    hit_flag  <= 1'b0;
                    state     <= PROBE_REQ;
                end
                PROBE_REQ: begin
                    if (!off_grid) state <= PROBE_RSP;
                end
                PROBE_RSP: begin
                    if ((tile_type == TILE_EMPTY) || (tile_type == TILE_BRICK))
                        arm[dir] <= step;
                    step  <= step + 3'd1;
                    state <= PROBE_REQ;
                end
                BURN: begin
                    if (ply_in && !hit_flag) begin
                        player_hit <= 1'b1;
                        hit_flag   <= 1'b1;
                    end
                    if (startOfFrame) begin
                        if (frame_cnt == FW'(BURN_FRAMES - 1)) begin
                            state        <= DONE;
                            flame_active <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    arm       <= '0;
                    frame_cnt <= '0;
                    hit_flag  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Closing a direction moves to the next arm, or into BURN after D
            if (close_dir) begin
                step <= 3'd1;
                if (dir == 2'd3) begin
                    state        <= BURN;
                    flame_active <= 1'b1;
                end else begin
                    dir   <= dir + 2'd1;
                    state <= PROBE_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_blast.sv
// tb_bomb_blast: scoreboard bench for bomb_blast. A behavioural model
// predicts the probe sequence, brick reports and arm lengths from a tile map.
module tb_bomb_blast;

    localparam int RANGE = 2;
    localparam int BURN  = 30;

    logic               clk = 1'b0;
    logic               reset, startOfFrame, blast;
    logic signed [10:0] bomb_topLeftX, bomb_topLeftY;
    logic               tile_req, destroy_valid;
    logic [4:0]         tile_col, destroy_col;
    logic [3:0]         tile_row, destroy_row;
    logic [1:0]         tile_type;
    logic [10:0]        pixelX, pixelY, player_topLeftX, player_topLeftY;
    logic               flame_active, flameDR, player_hit, done;

    always #5 clk = ~clk;

    bomb_blast #(.RANGE(RANGE), .BURN_FRAMES(BURN)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .blast(blast),
        .bomb_topLeftX(bomb_topLeftX), .bomb_topLeftY(bomb_topLeftY),
        .tile_req(tile_req), .tile_col(tile_col), .tile_row(tile_row),
        .tile_type(tile_type), .destroy_valid(destroy_valid),
        .destroy_col(destroy_col), .destroy_row(destroy_row),
        .pixelX(pixelX), .pixelY(pixelY),
        .player_topLeftX(player_topLeftX), .player_topLeftY(player_topLeftY),
        .flame_active(flame_active), .flameDR(flameDR),
        .player_hit(player_hit), .done(done)
    );

    // Tile map and its one-cycle-latency read port
    logic [1:0] tile_map [20][15];
    always @(posedge clk) tile_type <= tile_req ? tile_map[tile_col][tile_row] : 2'd0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard queues (col*16+row) and event counters
    int req_q[$];
    int dest_q[$];
    int n_req, n_dest, n_hit, n_done;
    int exp_nreq, exp_ndest;
    int exp_cx, exp_cy;
    int exp_arm[4];

    always @(negedge clk) begin
        if (tile_req) begin
            n_req++;
            if (req_q.size() == 0) check("req_extra", 1, 0);
            else check("req_tile", {tile_col, tile_row}, req_q.pop_front());
        end
        if (destroy_valid) begin
            n_dest++;
            if (dest_q.size() == 0) check("destroy_extra", 1, 0);
            else check("destroy_tile", {destroy_col, destroy_row}, dest_q.pop_front());
        end
        if (player_hit) n_hit++;
        if (done) n_done++;
    end

    // Behavioural model of the probe: pushes expected requests and bricks
    task automatic model_blast(input int x, input int y);
        int dc[4] = '{-1, 1, 0, 0};
        int dr[4] = '{0, 0, -1, 1};
        exp_cx = (x + 16) >>> 5;
        exp_cy = (y + 16) >>> 5;
        if (exp_cx < 0) exp_cx = 0;
        if (exp_cx > 19) exp_cx = 19;
        if (exp_cy < 0) exp_cy = 0;
        if (exp_cy > 14) exp_cy = 14;
        for (int d = 0; d < 4; d++) begin
            exp_arm[d] = 0;
            for (int k = 1; k <= RANGE; k++) begin
                int c;
                int r;
                c = exp_cx + dc[d] * k;
                r = exp_cy + dr[d] * k;
                if (c < 0 || c > 19 || r < 0 || r > 14) break;
                req_q.push_back(c * 16 + r);
                if (tile_map[c][r] == 2'd0) begin
                    exp_arm[d] = k;
                end else begin
                    if (tile_map[c][r] == 2'd2) begin
                        exp_arm[d] = k;
                        dest_q.push_back(c * 16 + r);
                    end
                    break;
                end
            end
        end
        exp_nreq  = req_q.size();
        exp_ndest = dest_q.size();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map();
        for (int c = 0; c < 20; c++)
            for (int r = 0; r < 15; r++)
                tile_map[c][r] = 2'd0;
    endtask

    // Pulse blast and check LATCH / first-request timing
    task automatic fire_blast(input int x, input int y, input logic exp_req_c2);
        n_req = 0; n_dest = 0; n_hit = 0; n_done = 0;
        model_blast(x, y);
        bomb_topLeftX = 11'(x);
        bomb_topLeftY = 11'(y);
        blast = 1'b1;
        tick();
        blast = 1'b0;
        check("latch_no_req", tile_req, 0);
        tick();
        check("req_cycle2", tile_req, exp_req_c2);
    endtask

    task automatic probe(input string tag, input int c, input int r, input logic exp);
        if (c < 0 || c > 19 || r < 0 || r > 14) return;
        pixelX = 11'(c * 32 + 5);
        pixelY = 11'(r * 32 + 5);
        #1;
        check(tag, flameDR, exp);
    endtask

    // Check the drawn cross: arm ends lit, one tile past each end dark
    task automatic check_cross();
        probe("pix_centre", exp_cx, exp_cy, 1'b1);
        probe("pix_left",   exp_cx - exp_arm[0], exp_cy, 1'b1);
        probe("pix_right",  exp_cx + exp_arm[1], exp_cy, 1'b1);
        probe("pix_up",     exp_cx, exp_cy - exp_arm[2], 1'b1);
        probe("pix_down",   exp_cx, exp_cy + exp_arm[3], 1'b1);
        probe("pix_left_out",  exp_cx - exp_arm[0] - 1, exp_cy, 1'b0);
        probe("pix_right_out", exp_cx + exp_arm[1] + 1, exp_cy, 1'b0);
        probe("pix_up_out",    exp_cx, exp_cy - exp_arm[2] - 1, 1'b0);
        probe("pix_down_out",  exp_cx, exp_cy + exp_arm[3] + 1, 1'b0);
        probe("pix_diag",      exp_cx + 1, exp_cy + 1, 1'b0);
        tick();
    endtask

    // Wait for the burn, check the cross, run the frames, check the end
    task automatic run_burn(input logic blast_in_burn, input int exp_hit);
        int cyc = 0;
        while (!flame_active && cyc < 100) begin
            tick();
            cyc++;
        end
        check("flame_rise", flame_active, 1);
        check("req_q_drained", req_q.size(), 0);
        check("dest_q_drained", dest_q.size(), 0);
        check_cross();
        if (blast_in_burn) begin
            blast = 1'b1;
            tick();
            blast = 1'b0;
            tick();
            check("blast_in_burn", flame_active, 1);
        end
        for (int i = 1; i <= BURN; i++) begin
            repeat (3) tick();
            if (i == BURN) check("flame_hold", flame_active, 1);
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
        check("done_pulse", done, 1);
        check("flame_fall", flame_active, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("req_count", n_req, exp_nreq);
        check("destroy_count", n_dest, exp_ndest);
        check("done_count", n_done, 1);
        check("hit_count", n_hit, exp_hit);
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; blast = 1'b0;
        bomb_topLeftX = '0; bomb_topLeftY = '0;
        pixelX = '0; pixelY = '0;
        player_topLeftX = 11'd1000; player_topLeftY = 11'd1000;
        clear_map();
        repeat (2) tick();
        reset = 1'b0;
        check("rst_tile_req", tile_req, 0);
        check("rst_destroy", destroy_valid, 0);
        check("rst_flame", flame_active, 0);
        check("rst_flameDR", flameDR, 0);
        check("rst_hit", player_hit, 0);
        check("rst_done", done, 0);

        // Open field: full arms, 8 requests
        fire_blast(320, 224, 1'b1);
        run_burn(1'b0, 0);

        // Walls: solid left, brick right; player right of centre; blasts ignored
        tile_map[9][7]  = 2'd1;
        tile_map[11][7] = 2'd2;
        player_topLeftX = 11'd352; player_topLeftY = 11'd224;
        fire_blast(320, 224, 1'b1);
        blast = 1'b1;
        tick();
        blast = 1'b0;
        run_burn(1'b1, 1);
        clear_map();

        // Corner: no left/up requests, centre tile drawn
        player_topLeftX = 11'd1000; player_topLeftY = 11'd1000;
        fire_blast(0, 0, 1'b0);
        run_burn(1'b0, 0);

        // Reset while a brick response is being consumed
        tile_map[9][7] = 2'd2;
        fire_blast(320, 224, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_no_destroy", destroy_valid, 0);
        tick();
        reset = 1'b0;
        req_q.delete();
        dest_q.delete();
        check("rst_mid_tile_req", tile_req, 0);
        check("rst_mid_flame", flame_active, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_hit", player_hit, 0);
        repeat (3) tick();
        check("rst_mid_idle_reqs", n_req, 1);
        check("rst_mid_destroys", n_dest, 0);
        clear_map();

        // Fresh blast after reset; player just below the right arm is safe
        player_topLeftX = 11'd352; player_topLeftY = 11'd256;
        fire_blast(320, 224, 1'b1);
        run_burn(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bomb_blast.md
# bomb_blast

Consumes the bomb's one-cycle blast pulse and bomb top-left position, and turns it into a cross-shaped flame on the 32x32-pixel tile grid. The flame covers 20 columns x 15 rows of the 640x480 screen. The block probes the maze tile map through a synchronous request/response port to find how far each arm extends, and reports destroyed brick tiles. It then holds the flame for a fixed number of frames, drives a per-pixel draw request to the video mux, and flags a player hit.

## Interface
Parameters:
- RANGE, 2: maximum arm length in tiles (1..7).
- BURN_FRAMES, 30: number of startOfFrame pulses the flame stays visible.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- blast  in  1  one-cycle pulse from the bomb; the bomb position is valid in the same cycle.
- bomb_topLeftX  in  11 signed  bomb top-left X in pixels.
- bomb_topLeftY  in  11 signed  bomb top-left Y in pixels.
- tile_req  out  1  one-cycle tile-map read strobe.
- tile_col  out  5  column being read (0..19).
- tile_row  out  4  row being read (0..14).
- tile_type  in  2  tile-map response, valid exactly 1 cycle after tile_req: 0 = empty, 1 = solid, 2 = brick, 3 = treated as solid.
- destroy_valid  out  1  one-cycle pulse: the brick at destroy_col/destroy_row is consumed.
- destroy_col  out  5  column of the destroyed brick.
- destroy_row  out  4  row of the destroyed brick.
- pixelX  in  11  current VGA pixel X.
- pixelY  in  11  current VGA pixel Y.
- player_topLeftX  in  11  player top-left X in pixels.
- player_topLeftY  in  11  player top-left Y in pixels.
- flame_active  out  1  high throughout the burn.
- flameDR  out  1  combinational draw request: high when flame_active is high and the pixel lies in the flame cross.
- player_hit  out  1  one-cycle pulse, at most once per burn.
- done  out  1  one-cycle pulse when the burn ends.

## Operation
States: IDLE, LATCH, PROBE_REQ, PROBE_RSP, BURN, DONE.

IDLE:
- On blast, register the bomb position and go to LATCH.
- A blast in any other state is ignored.

LATCH (one cycle):
- Compute the centre tile with 12-bit signed arithmetic: cx = (X+16)>>>5 and cy = (Y+16)>>>5.
- Clamp cx to 0..19 and cy to 0..14.
- Clear the arm lengths L/R/U/D (3 bits each), the direction index d = 0 (order L, R, U, D) and the step k = 1.

PROBE_REQ:
- Target tile is the centre offset by k in direction d.
- If the target is off-grid (col < 0, col > 19, row < 0, row > 14), close direction d with no request issued: advance d, reset k = 1 and stay in PROBE_REQ. This step takes 1 cycle.
- Otherwise pulse tile_req with the target coordinates and go to PROBE_RSP.

PROBE_RSP (samples tile_type):
- Empty: arm[d] = k. If k == RANGE, close direction d; otherwise k++.
- Brick: arm[d] = k, pulse destroy_valid with the target coordinates in this cycle, then close direction d.
- Solid or 3: close direction d; arm[d] keeps its prior value.
- Return to PROBE_REQ, or go to BURN when direction D closes.

BURN:
- flame_active = 1; the frame counter counts startOfFrame pulses.
- Flame cross is the centre tile plus arm tiles, as pixel rectangles:
  - horizontal: cols cx-L .. cx+R, row cy;
  - vertical: rows cy-U .. cy+D, column cx.
- flameDR = flame_active & (pixel in either rectangle). Bounds are registered, so the comparison is combinational only.
- Player test: tile of the player centre, computed as (topLeft+16)>>5.
  - If that tile lies in the cross and the hit flag is clear, pulse player_hit and set the flag.
  - The test is evaluated every cycle in BURN.
- When the counter reaches BURN_FRAMES, go to DONE.

DONE:
- Pulse done, clear flame_active and the arms, go to IDLE.

## Timing
- Blast at cycle 0: LATCH in cycle 1, first tile_req in cycle 2 (when the first target is on-grid).
- Each on-grid step costs 2 cycles; each off-grid step costs 1 cycle. Worst-case probe is 8*RANGE cycles.
- flame_active rises on the first BURN cycle.
- flame_active falls, and done pulses, the cycle after the BURN_FRAMES-th startOfFrame.
- A startOfFrame during LATCH or PROBE is not counted.
- At most one tile_req per 2 cycles. destroy_valid is never asserted outside PROBE_RSP.
- Reset values: state IDLE, all outputs 0, arms 0, hit flag 0, counters 0.
- Reset asserted in any state: everything returns to reset values on the next clk edge. No destroy_valid or done is emitted.

## Test plan
- Open field: bomb at (320,224) (centre tile 10,7), RANGE 2, all tiles empty -> 8 tile_reqs; L = R = U = D = 2; flame_active for 30 frames; one done pulse.
- Walls: solid at (9,7), brick at (11,7) -> L = 0, R = 1; exactly one destroy_valid with col 11, row 7; only 1 request issued to the right.
- Corner: bomb at (0,0) -> no requests to the left or up; L = U = 0; centre tile (0,0) drawn; flameDR at pixel (5,5) = 1 during BURN.
- Player hit: player at (352,224) with R ≥ 1 -> exactly one player_hit pulse across the whole burn. Player at (352,256) -> no pulse.
- Blast ignored: second blast pulse during PROBE and during BURN -> no state change, request count unchanged.
- Reset mid-PROBE: assert reset in PROBE_RSP -> next cycle IDLE, all outputs 0. A subsequent blast behaves as a fresh one.
